// File: rtl/foc_pkg.sv
`default_nettype none
// ============================================================================
// foc_pkg
// Shared types and constants for the field-oriented-control datapath blocks.
// Revision: 1.0 - initial release
// ============================================================================
package foc_pkg;

  // Default datapath width and Q-format fractional bits for sin/cos operands
  localparam int DATA_W = 16;
  localparam int FRAC   = 15;

  // Q15 saturation limits applied to every result leaving a FOC block
  localparam int Q15_MAX = 32767;
  localparam int Q15_MIN = -32768;

  // Transform sequencer encoding; 2'd3 is unused and recovers to IDLE
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_SUM  = 2'd2
  } state_t;

endpackage : foc_pkg
`default_nettype wire

// File: rtl/q15_mul.sv
`default_nettype none
// ============================================================================
// q15_mul
// Combinational signed multiply followed by an arithmetic right shift by FRAC.
// The shift floors toward minus infinity; one extra result bit holds the
// single overflow case (-1.0 * -1.0).
// Revision: 1.0 - initial release
// ============================================================================
module q15_mul #(
  parameter int DATA_W = foc_pkg::DATA_W,
  parameter int FRAC   = foc_pkg::FRAC
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W:0]   p
);

  logic signed [2*DATA_W-1:0] full;

  assign full = a * b;
  assign p    = (DATA_W+1)'(full >>> FRAC);

endmodule : q15_mul
`default_nettype wire

// File: rtl/park.sv
`default_nettype none
// ============================================================================
// park
// Park transform (alpha/beta -> d/q) using one shared Q15 multiplier over four
// sequential MUL cycles, one SUM cycle with saturation, and a registered
// completion pulse six edges after the capture edge.
// Revision: 1.0 - initial release
// ============================================================================
module park #(
  parameter int DATA_W = foc_pkg::DATA_W,
  parameter int FRAC   = foc_pkg::FRAC
) (
  input  logic                     iClk,
  input  logic                     iRst_n,
  input  logic                     iPark_en,
  input  logic signed [DATA_W-1:0] iSin,
  input  logic signed [DATA_W-1:0] iCos,
  input  logic signed [DATA_W-1:0] iIalpha,
  input  logic signed [DATA_W-1:0] iIbeta,
  output logic                     oPark_done,
  output logic                     oBusy,
  output logic signed [DATA_W-1:0] oId,
  output logic signed [DATA_W-1:0] oIq
);

  import foc_pkg::*;

  localparam int PW = DATA_W + 1;   // shifted product width
  localparam int SW = DATA_W + 2;   // sum/difference width

  localparam logic signed [SW-1:0] SAT_HI = SW'(Q15_MAX);
  localparam logic signed [SW-1:0] SAT_LO = SW'(Q15_MIN);

  state_t                    state;
  logic [1:0]                cnt;
  logic                      en_q;
  logic                      armed;      // set once iPark_en has been seen low after reset
  logic                      done_arm;   // results written; pulse done on next edge
  logic                      start;

  logic signed [DATA_W-1:0]  sin_r, cos_r, ia_r, ib_r;
  logic signed [DATA_W-1:0]  mul_a, mul_b;
  logic signed [PW-1:0]      prod;
  logic signed [PW-1:0]      p_ac, p_bs, p_bc, p_as;
  logic signed [SW-1:0]      d_sum, q_sum;

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [SW-1:0] v);
    if (v > SAT_HI)      return SAT_HI[DATA_W-1:0];
    else if (v < SAT_LO) return SAT_LO[DATA_W-1:0];
    else                 return DATA_W'(v);
  endfunction

  assign start = iPark_en & ~en_q & armed & (state == ST_IDLE);

  // Operand select for the shared multiplier, sequenced by the MUL counter
  always_comb begin
    mul_a = ia_r;
    mul_b = cos_r;
    case (cnt)
      2'd0: begin mul_a = ia_r; mul_b = cos_r; end
      2'd1: begin mul_a = ib_r; mul_b = sin_r; end
      2'd2: begin mul_a = ib_r; mul_b = cos_r; end
      2'd3: begin mul_a = ia_r; mul_b = sin_r; end
      default: ;
    endcase
  end

  q15_mul #(
    .DATA_W (DATA_W),
    .FRAC   (FRAC)
  ) u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (prod)
  );

  // Widen the stored products before combining so the sums cannot wrap
  always_comb begin
    d_sum = $signed({p_ac[PW-1], p_ac}) + $signed({p_bs[PW-1], p_bs});
    q_sum = $signed({p_bc[PW-1], p_bc}) - $signed({p_as[PW-1], p_as});
  end

  // Transform sequencer: capture, four multiplies, sum/saturate, done pulse
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state      <= ST_IDLE;
      cnt        <= 2'd0;
      en_q       <= 1'b0;
      armed      <= 1'b0;
      done_arm   <= 1'b0;
      sin_r      <= '0;
      cos_r      <= '0;
      ia_r       <= '0;
      ib_r       <= '0;
      p_ac       <= '0;
      p_bs       <= '0;
      p_bc       <= '0;
      p_as       <= '0;
      oId        <= '0;
      oIq        <= '0;
      oPark_done <= 1'b0;
      oBusy      <= 1'b0;
    end else begin
      en_q       <= iPark_en;
      oPark_done <= done_arm;
      done_arm   <= 1'b0;
      if (!iPark_en) armed <= 1'b1;
      if (done_arm)  oBusy <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            sin_r <= iSin;
            cos_r <= iCos;
            ia_r  <= iIalpha;
            ib_r  <= iIbeta;
            cnt   <= 2'd0;
            oBusy <= 1'b1;
            state <= ST_MUL;
          end
        end
        ST_MUL: begin
          case (cnt)
            2'd0:    p_ac <= prod;
            2'd1:    p_bs <= prod;
            2'd2:    p_bc <= prod;
            default: p_as <= prod;
          endcase
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) state <= ST_SUM;
        end
        ST_SUM: begin
          oId      <= sat(d_sum);
          oIq      <= sat(q_sum);
          done_arm <= 1'b1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule : park
`default_nettype wire

// File: tb/tb_park.sv
`default_nettype none
// ============================================================================
// tb_park
// Self-checking bench for the Park transform block.
// Revision: 1.0 - initial release
// ============================================================================
module tb_park;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic signed [15:0] sin_i, cos_i, ia_i, ib_i;
  logic               done, busy;
  logic signed [15:0] id_o, iq_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  park #(.DATA_W(16), .FRAC(15)) dut (
    .iClk       (clk),
    .iRst_n     (rst_n),
    .iPark_en   (en),
    .iSin       (sin_i),
    .iCos       (cos_i),
    .iIalpha    (ia_i),
    .iIbeta     (ib_i),
    .oPark_done (done),
    .oBusy      (busy),
    .oId        (id_o),
    .oIq        (iq_o)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: exact products floored by 2^15, summed, then clamped to Q15
  function automatic logic signed [15:0] clamp(input longint v);
    if (v > 32767)  return 16'sd32767;
    if (v < -32768) return -16'sd32768;
    return 16'(v);
  endfunction

  function automatic longint qmul(input longint a, input longint b);
    longint p;
    p = a * b;
    return p >>> 15;
  endfunction

  task automatic model(input logic signed [15:0] s, c, a, b,
                       output logic signed [15:0] eid, eiq);
    eid = clamp(qmul(a, c) + qmul(b, s));
    eiq = clamp(qmul(b, c) - qmul(a, s));
  endtask

  // One transform: raise en, then sample after edges 0..8 of the capture
  task automatic run_xform(input string tag, input logic signed [15:0] s, c, a, b,
                           input logic signed [15:0] eid, eiq, input bit retrig);
    int done_cnt;
    done_cnt = 0;
    @(negedge clk);
    sin_i = s; cos_i = c; ia_i = a; ib_i = b; en = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("%s_busy%0d", tag, k), busy, (k <= 5));
      check($sformatf("%s_done%0d", tag, k), done, (k == 6));
      done_cnt += int'(done);
      if (k == 6) begin
        check({tag, "_id"}, id_o, eid);
        check({tag, "_iq"}, iq_o, eiq);
      end
      if (k == 0) begin
        en = 1'b0;
        sin_i = 16'($urandom); cos_i = 16'($urandom);
        ia_i  = 16'($urandom); ib_i  = 16'($urandom);
      end
      if (retrig && k == 1) en = 1'b1;
      if (k == 3) en = 1'b0;
    end
    check({tag, "_id_hold"}, id_o, eid);
    check({tag, "_iq_hold"}, iq_o, eiq);
    check({tag, "_done_pulses"}, done_cnt, 1);
  endtask

  initial begin
    logic signed [15:0] s, c, a, b, eid, eiq;
    int done_cnt, busy_cnt, done_idx, last_busy;

    rst_n = 1'b0; en = 1'b0;
    sin_i = '0; cos_i = '0; ia_i = '0; ib_i = '0;
    repeat (3) @(negedge clk);
    check("rst_id", id_o, 0);
    check("rst_iq", iq_o, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed vectors with hand-derived results
    run_xform("d_cos1", 16'sd0, 16'sd32767, 16'sd10000, -16'sd5000,
              16'sd9999, -16'sd5000, 1'b0);
    run_xform("d_sin1", 16'sd32767, 16'sd0, 16'sd10000, -16'sd5000,
              -16'sd5000, -16'sd9999, 1'b0);
    run_xform("d_satp", 16'sd23170, 16'sd23170, 16'sd32767, 16'sd32767,
              16'sd32767, 16'sd0, 1'b0);
    run_xform("d_satn", 16'sd23170, 16'sd23170, -16'sd32768, -16'sd32768,
              -16'sd32768, 16'sd0, 1'b0);

    // Randomized transforms against the reference model
    for (int i = 0; i < 12; i++) begin
      s = 16'($urandom); c = 16'($urandom);
      a = 16'($urandom); b = 16'($urandom);
      if (i == 0) begin s = -16'sd32768; c = -16'sd32768; a = -16'sd32768; b = 16'sd32767; end
      model(s, c, a, b, eid, eiq);
      run_xform($sformatf("rand%0d", i), s, c, a, b, eid, eiq, 1'b0);
    end

    // Retrigger while busy: ignored, result from the first operands
    s = 16'($urandom); c = 16'($urandom); a = 16'($urandom); b = 16'($urandom);
    model(s, c, a, b, eid, eiq);
    run_xform("retrig", s, c, a, b, eid, eiq, 1'b1);

    // Reset three cycles into a transform aborts it
    @(negedge clk);
    sin_i = 16'sd1000; cos_i = 16'sd30000; ia_i = 16'sd20000; ib_i = 16'sd12000;
    en = 1'b1;
    @(posedge clk);
    @(negedge clk); en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_id", id_o, 0);
    check("abort_iq", iq_o, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0; busy_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      done_cnt += int'(done);
      busy_cnt += int'(busy);
    end
    check("abort_no_done", done_cnt, 0);
    check("abort_no_busy", busy_cnt, 0);
    s = 16'($urandom); c = 16'($urandom); a = 16'($urandom); b = 16'($urandom);
    model(s, c, a, b, eid, eiq);
    run_xform("post_abort", s, c, a, b, eid, eiq, 1'b0);

    // Release reset with en already high: no start until en falls and rises
    @(negedge clk);
    rst_n = 1'b0; en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0; busy_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      done_cnt += int'(done);
      busy_cnt += int'(busy);
    end
    check("en_high_rel_done", done_cnt, 0);
    check("en_high_rel_busy", busy_cnt, 0);
    en = 1'b0;
    @(negedge clk);
    s = 16'($urandom); c = 16'($urandom); a = 16'($urandom); b = 16'($urandom);
    model(s, c, a, b, eid, eiq);
    run_xform("after_rel", s, c, a, b, eid, eiq, 1'b0);

    // en held high for 20 cycles: one transform, busy for the 6 cycles before done
    s = 16'($urandom); c = 16'($urandom); a = 16'($urandom); b = 16'($urandom);
    model(s, c, a, b, eid, eiq);
    @(negedge clk);
    sin_i = s; cos_i = c; ia_i = a; ib_i = b; en = 1'b1;
    done_cnt = 0; busy_cnt = 0; done_idx = -1; last_busy = -1;
    @(posedge clk);
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done) begin done_cnt++; done_idx = k; end
      if (busy) begin busy_cnt++; last_busy = k; end
      if (k == 19) en = 1'b0;
    end
    check("hold_done_pulses", done_cnt, 1);
    check("hold_busy_cycles", busy_cnt, 6);
    check("hold_done_idx", done_idx, 6);
    check("hold_busy_end", last_busy, 5);
    check("hold_id", id_o, eid);
    check("hold_iq", iq_o, eiq);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_park
`default_nettype wire

// File: doc/park.md
PARK -- requirements
Module: park

Interface
REQ-001 Parameter: DATA_W, default 16, signed data width of all angle and current ports.
REQ-002 Parameter: FRAC, default 15, fractional bits of iSin/iCos (Q1.15); products are shifted right by FRAC.
REQ-003 Port: iClk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: iRst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: iPark_en  input  1  start request; a rising edge starts one transform.
REQ-006 Port: iSin  input  DATA_W  signed sin(theta), Q1.15.
REQ-007 Port: iCos  input  DATA_W  signed cos(theta), Q1.15.
REQ-008 Port: iIalpha  input  DATA_W  signed alpha-axis current.
REQ-009 Port: iIbeta  input  DATA_W  signed beta-axis current.
REQ-010 Port: oPark_done  output  1  one-cycle completion pulse.
REQ-011 Port: oBusy  output  1  high from the capture edge until oPark_done asserts.
REQ-012 Port: oId  output  DATA_W  signed d-axis result, registered.
REQ-013 Port: oIq  output  DATA_W  signed q-axis result, registered.

Function
REQ-014 Transform: Id = Ialpha*cos + Ibeta*sin; Iq = Ibeta*cos - Ialpha*sin.
REQ-015 Start: iPark_en is registered each cycle; a start is detected when iPark_en=1 and the registered copy=0 while state is IDLE.
REQ-016 On the start edge, iSin, iCos, iIalpha, iIbeta are latched; they are not sampled again during the transform.
REQ-017 States: IDLE -> MUL (4 cycles) -> SUM (1 cycle) -> IDLE; no other states reachable; illegal encodings return to IDLE.
REQ-018 MUL uses one shared signed DATA_W x DATA_W multiplier; a 2-bit counter selects, in order, Ialpha*cos, Ibeta*sin, Ibeta*cos, Ialpha*sin.
REQ-019 Each full 2*DATA_W product is arithmetically shifted right by FRAC (floor toward minus infinity) and stored in its own DATA_W+1-bit register.
REQ-020 SUM forms both sums/differences at DATA_W+2 bits, saturates to [-32768, 32767], writes oId/oIq, and sets oPark_done=1.
REQ-021 Latency: oPark_done is high in the cycle starting exactly 6 rising edges after the capture edge (capture edge = edge 0: 4 MUL edges + 1 SUM edge + done visible); high for exactly one cycle.
REQ-022 oId/oIq hold their value between completions; they update only in SUM.
REQ-023 Rising edges of iPark_en while not IDLE are ignored, not queued.
REQ-024 A rising edge coincident with the SUM-to-IDLE transition is ignored; a new start needs iPark_en low then high again.
REQ-025 iPark_en held high continuously produces exactly one transform.

Reset
REQ-026 On iRst_n low, immediately: state=IDLE, counter=0, enable register=0, product registers=0, oId=0, oIq=0, oPark_done=0, oBusy=0.
REQ-027 Reset mid-transform aborts it; no oPark_done is produced for the aborted transform.
REQ-028 After reset release with iPark_en already high, no start occurs until iPark_en falls and rises.

Structure
REQ-029 Shared package foc_pkg holds DATA_W, FRAC, Q15 saturation limits (32767/-32768), and the state encoding constants.
REQ-030 One sub-module q15_mul: signed multiply plus arithmetic right shift by FRAC, combinational, reused by later FOC blocks.

Verification
REQ-031 sin=0, cos=32767, Ialpha=10000, Ibeta=-5000, pulse en -> oId=9999, oIq=-5000, done 6 edges after capture.
REQ-032 sin=32767, cos=0, Ialpha=10000, Ibeta=-5000 -> oId=-5000, oIq=-9999.
REQ-033 sin=cos=23170, Ialpha=Ibeta=32767 -> oId=32767 (saturated), oIq=0; then Ialpha=Ibeta=-32768 -> oId=-32768, oIq=0.
REQ-034 Second en rising edge 2 cycles after first, with changed inputs -> single done pulse, results from first inputs only.
REQ-035 Assert iRst_n low 3 cycles after start -> outputs 0, no done pulse; after release, a fresh edge gives correct results.
REQ-036 Hold iPark_en high for 20 cycles -> exactly one oPark_done pulse; oBusy high for exactly the 6 cycles ending with done.
